// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: decodes opcode/funct/zero into datapath selects,
// enables and ALU control, and handshakes with a variable-latency memory.
module mips_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPEEX  = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCHEX = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JEX      = 4'd11
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b101;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t cur, nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= FETCH;
    else       cur <= nxt;
  end

  assign state = cur;

  always_comb begin
    nxt         = FETCH;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    case (cur)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        nxt       = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b100011, 6'b101011: nxt = MEMADR;
          6'b000000:            nxt = RTYPEEX;
          6'b000100, 6'b000101: nxt = BRANCHEX;
          6'b001000:            nxt = ADDIEX;
          6'b000010:            nxt = JEX;
          default:              illegal = 1'b1;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = (opcode == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        nxt     = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        nxt       = mem_ready ? FETCH : MEMWR;
      end
      RTYPEEX: begin
        alu_src_a = 1'b1;
        nxt       = RTYPEWB;
        case (funct)
          6'b100000: alu_control = ALU_ADD;
          6'b100010: alu_control = ALU_SUB;
          6'b100100: alu_control = ALU_AND;
          6'b100101: alu_control = ALU_OR;
          6'b101010: alu_control = ALU_SLT;
          default: begin
            illegal = 1'b1;
            nxt     = FETCH;
          end
        endcase
      end
      RTYPEWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      BRANCHEX: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        pc_en       = (opcode == 6'b000100) ? zero : ~zero;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        nxt       = ADDIWB;
      end
      ADDIWB: reg_write = 1'b1;
      JEX: begin
        pc_src = 2'b10;
        pc_en  = 1'b1;
      end
      default: nxt = FETCH;
    endcase
    // Reset masks every strobe; state is already FETCH so selects match FETCH.
    if (reset) begin
      mem_req   = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      pc_en     = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class through
// its state sequence and checks outputs against hand-computed values.
module tb_mips_multicycle_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_req, mem_write, iord, ir_write, pc_en;
  logic [1:0] pc_src, alu_src_b;
  logic       alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
  logic [2:0] alu_control;
  logic [3:0] state;

  int unsigned total = 0;
  int unsigned bad   = 0;

  mips_multicycle_ctrl dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
    chk("strobe_excl", (32'(reg_write) + 32'(mem_write) + 32'(ir_write)) <= 1, 1);
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_memreq", mem_req, 0);
    chk("rst_srcb", alu_src_b, 1);
    tick();
    chk("rst_state2", state, 0);
    reset = 1'b0;
    #1;
    chk("rel_memreq", mem_req, 1);
    chk("rel_irw_wait", ir_write, 0);
    tick();
    chk("fetch_wait", state, 0);

    // lw
    opcode = 6'b100011; mem_ready = 1'b1;
    #1;
    chk("lw_irw", ir_write, 1);
    chk("lw_pcen", pc_en, 1);
    tick(); chk("lw_s1", state, 1); chk("lw_dec_srcb", alu_src_b, 3); chk("lw_dec_ill", illegal, 0);
    tick(); chk("lw_s2", state, 2); chk("lw_adr_srca", alu_src_a, 1); chk("lw_adr_srcb", alu_src_b, 2);
    chk("lw_adr_rw", reg_write, 0);
    tick(); chk("lw_s3", state, 3); chk("lw_rd_req", mem_req, 1); chk("lw_rd_iord", iord, 1);
    chk("lw_rd_rw", reg_write, 0);
    tick(); chk("lw_s4", state, 4); chk("lw_wb_rw", reg_write, 1); chk("lw_wb_m2r", mem_to_reg, 1);
    chk("lw_wb_dst", reg_dst, 0);
    tick(); chk("lw_s0", state, 0);

    // sw with three wait cycles
    opcode = 6'b101011;
    tick(); chk("sw_s1", state, 1);
    tick(); chk("sw_s2", state, 2);
    mem_ready = 1'b0;
    tick(); chk("sw_s5", state, 5); chk("sw_mw", mem_write, 1); chk("sw_rw", reg_write, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("sw_hold", state, 5); chk("sw_hold_mw", mem_write, 1); chk("sw_hold_rw", reg_write, 0);
    end
    mem_ready = 1'b1;
    tick(); chk("sw_done", state, 0);

    // R-type sub
    opcode = 6'b000000; funct = 6'b100010;
    tick(); chk("rt_s1", state, 1);
    tick(); chk("rt_s6", state, 6); chk("rt_aluc", alu_control, 5); chk("rt_srcb", alu_src_b, 0);
    chk("rt_srca", alu_src_a, 1);
    tick(); chk("rt_s7", state, 7); chk("rt_dst", reg_dst, 1); chk("rt_rw", reg_write, 1);
    chk("rt_m2r", mem_to_reg, 0);
    tick(); chk("rt_s0", state, 0);

    // R-type illegal funct
    funct = 6'b000111;
    tick(); chk("rti_s1", state, 1);
    tick(); chk("rti_s6", state, 6); chk("rti_ill", illegal, 1); chk("rti_aluc", alu_control, 1);
    chk("rti_rw", reg_write, 0);
    tick(); chk("rti_s0", state, 0); chk("rti_rw2", reg_write, 0);

    // beq taken
    opcode = 6'b000100; zero = 1'b1;
    tick(); chk("beq_s1", state, 1);
    tick(); chk("beq_s8", state, 8); chk("beq_pcen", pc_en, 1); chk("beq_pcsrc", pc_src, 1);
    chk("beq_aluc", alu_control, 5);
    tick(); chk("beq_s0", state, 0);

    // bne: zero=1 not taken, zero=0 taken
    opcode = 6'b000101;
    tick(); chk("bne_s1", state, 1);
    tick(); chk("bne_s8", state, 8); chk("bne_nt", pc_en, 0);
    zero = 1'b0; #1;
    chk("bne_t", pc_en, 1);
    tick(); chk("bne_s0", state, 0);

    // j
    opcode = 6'b000010;
    tick(); chk("j_s1", state, 1);
    tick(); chk("j_s11", state, 11); chk("j_pcen", pc_en, 1); chk("j_pcsrc", pc_src, 2);
    tick(); chk("j_s0", state, 0);

    // illegal opcode
    opcode = 6'b111111;
    tick(); chk("iop_s1", state, 1); chk("iop_ill", illegal, 1);
    tick(); chk("iop_s0", state, 0); chk("iop_ill_clr", illegal, 0);

    // reset mid-MEMRD
    opcode = 6'b100011;
    tick(); chk("rm_s1", state, 1);
    tick(); chk("rm_s2", state, 2);
    mem_ready = 1'b0;
    tick(); chk("rm_s3", state, 3); chk("rm_req", mem_req, 1);
    #1 reset = 1'b1;
    #1;
    chk("rm_state", state, 0); chk("rm_req0", mem_req, 0); chk("rm_iord", iord, 0);
    mem_ready = 1'b1;
    #1;
    chk("rm_irw", ir_write, 0); chk("rm_pcen", pc_en, 0);
    tick(); chk("rm_hold", state, 0);
    reset = 1'b0;
    #1;
    chk("rm_rel_req", mem_req, 1); chk("rm_rel_irw", ir_write, 1);
    tick(); chk("rm_rel_s1", state, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Control FSM for the multicycle MIPS core. Decodes the instruction-register `opcode`/`funct` fields and the ALU `zero` flag into the per-cycle select, enable and ALU-control signals that drive the shared 32-bit datapath (`mux2_32`/`mux4_32` selects, `alu_32` control, register-file and memory strobes). It also handshakes with a variable-latency unified instruction/data memory.

## Interface
- No parameters. The state encoding and opcodes are fixed.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces state FETCH.
- `opcode`  in  6  instr[31:26] from the instruction register.
- `funct`  in  6  instr[5:0] from the instruction register.
- `zero`  in  1  ALU zero flag, same cycle.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access active.
- `mem_write`  out  1  access is a store.
- `iord`  out  1  address mux: 0 = PC, 1 = ALUOut.
- `ir_write`  out  1  load the instruction register.
- `pc_en`  out  1  PC register enable.
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a`  out  1  0 = PC, 1 = reg A.
- `alu_src_b`  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2.
- `alu_control`  out  3  add 001, sub 101, and 011, or 010, slt 111.
- `reg_dst`  out  1  0 = rt, 1 = rd.
- `mem_to_reg`  out  1  0 = ALUOut, 1 = memory data register.
- `reg_write`  out  1  register-file write enable.
- `illegal`  out  1  one-cycle pulse on an unsupported opcode or funct.
- `state`  out  4  current state, for debug and verification.

## Operation
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BRANCHEX 8, ADDIEX 9, ADDIWB 10, JEX 11.
- In every state, any output not listed is 0, with `alu_control` = 001.
- FETCH:
  - Outputs: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, add, `pc_src`=00.
  - `ir_write` = `pc_en` = `mem_ready`.
  - Next state: DECODE if `mem_ready`, else FETCH.
- DECODE:
  - Outputs: `alu_src_a`=0, `alu_src_b`=11, add (branch target into ALUOut).
  - Next state by opcode: 100011 lw / 101011 sw → MEMADR; 000000 → RTYPEEX; 000100 beq / 000101 bne → BRANCHEX; 001000 addi → ADDIEX; 000010 j → JEX.
  - Any other opcode: `illegal`=1 this cycle, next FETCH.
- MEMADR:
  - Outputs: `alu_src_a`=1, `alu_src_b`=10, add.
  - Next state: MEMRD for lw, MEMWR for sw.
- MEMRD:
  - Outputs: `mem_req`=1, `iord`=1.
  - Next state: MEMWB if `mem_ready`, else MEMRD.
- MEMWB: `reg_dst`=0, `mem_to_reg`=1, `reg_write`=1; next FETCH.
- MEMWR:
  - Outputs: `mem_req`=1, `mem_write`=1, `iord`=1.
  - Next state: FETCH if `mem_ready`, else MEMWR.
- RTYPEEX:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00.
  - `alu_control` from funct: 100000 → 001, 100010 → 101, 100100 → 011, 100101 → 010, 101010 → 111.
  - Legal funct: next RTYPEWB. Other funct: `illegal`=1, next FETCH, no writeback.
- RTYPEWB: `reg_dst`=1, `mem_to_reg`=0, `reg_write`=1; next FETCH.
- BRANCHEX:
  - Outputs: `alu_src_a`=1, `alu_src_b`=00, sub, `pc_src`=01.
  - `pc_en` = `zero` for beq, `~zero` for bne.
  - Next state: FETCH.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, add; next ADDIWB.
- ADDIWB: `reg_dst`=0, `mem_to_reg`=0, `reg_write`=1; next FETCH.
- JEX: `pc_src`=10, `pc_en`=1; next FETCH.
- Inputs `opcode`/`funct` are sampled only in DECODE, MEMADR, RTYPEEX and BRANCHEX. The IR holds them stable from the end of FETCH.

## Timing
- Reset:
  - While `reset`=1: state = FETCH (0) immediately, asynchronously.
  - All strobes (`mem_req`, `mem_write`, `ir_write`, `pc_en`, `reg_write`, `illegal`) are forced to 0.
  - Select outputs take their FETCH values.
  - First fetch request issues in the cycle after deassertion.
- Reset mid-instruction: abort with no further strobes. A pending memory access is dropped; memory must ignore `mem_ready` during reset.
- Outputs are combinational from the state register. The Mealy terms are `mem_ready` in FETCH, `zero` in BRANCHEX, and opcode/funct for `illegal` and `alu_control`.
- Latency with `mem_ready` tied to 1: lw 5 cycles, sw 4, R-type 4, addi 4, beq/bne 3, j 3, illegal opcode 2.
- Each cycle of low `mem_ready` in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs hold steady during the wait.
- At most one of `reg_write`, `mem_write`, `ir_write` is high in any cycle.

## Test plan
- Reset asserted mid-MEMRD (state=3) → `state`=0 and all strobes 0 within the same cycle; after release, FETCH with `mem_req`=1.
- lw (opcode 100011), `mem_ready`=1 → states 0,1,2,3,4,0.
  - `reg_write`=1 only in state 4, with `mem_to_reg`=1 and `reg_dst`=0.
- sw with `mem_ready` low for 3 cycles in MEMWR → state 5 held for 4 cycles with `mem_write`=1, then FETCH; `reg_write` never high.
- R-type: funct 100010 → state 6 with `alu_control`=101, then state 7 with `reg_dst`=1.
  - funct 000111 → `illegal`=1 in state 6, next state 0, no `reg_write`.
- beq with `zero`=1 → `pc_en`=1 and `pc_src`=01 in state 8. bne with `zero`=1 → `pc_en`=0.
- j → state 11 with `pc_en`=1 and `pc_src`=10. Opcode 111111 → `illegal` pulse in DECODE, back to FETCH after 2 cycles.
